// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined adder: stage-count calculation and the flag bundle
// carried by the final stage when PIPE_ADDER_FLAGS_EN is defined.
package adder_pkg;

  function automatic int chunk_count(input int width, input int chunk);
    return (chunk > 0) ? (width / chunk) : 1;
  endfunction

  typedef struct packed {
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit adder slice: {cout, sum} = a + b + cin.
module adder_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined carry-chain adder/subtractor, one CHUNK-bit slice per stage, global valid/ready stall.
// Optional ovf/zero/neg flag ports are built when PIPE_ADDER_FLAGS_EN is defined.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADDER_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero,
  output logic             neg
`endif
);

  localparam int STAGES = chunk_count(WIDTH, CHUNK);

  if ((CHUNK <= 0) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
    $error("pipelined_adder: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  // Every stage carries the full-width operands; stage k fills psum[k*CHUNK +: CHUNK].
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] pa;
    logic [WIDTH-1:0] pb;
  } stage_t;

  stage_t stg_p [STAGES];
  logic   adv;

  // A held result at the output freezes the whole pipe; bubbles are not squeezed out.
  assign adv      = !(stg_p[STAGES-1].valid && !out_ready);
  assign in_ready = adv;

`ifdef PIPE_ADDER_FLAGS_EN
  flags_t flags_p;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           src;
    stage_t           nxt;
    logic [CHUNK-1:0] cs;
    logic             co;

    // Stage boundary: stage 0 folds subtraction into b' = ~b with carry-in forced to 1.
    if (k == 0) begin : g_head
      always_comb begin
        src       = '0;
        src.valid = in_valid;
        src.carry = sub ? 1'b1 : cin;
        src.pa    = a;
        src.pb    = sub ? ~b : b;
      end
    end else begin : g_body
      assign src = stg_p[k-1];
    end

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a    (src.pa[k*CHUNK +: CHUNK]),
      .b    (src.pb[k*CHUNK +: CHUNK]),
      .cin  (src.carry),
      .sum  (cs),
      .cout (co)
    );

    always_comb begin
      nxt                          = src;
      nxt.carry                    = co;
      nxt.psum[k*CHUNK +: CHUNK]   = cs;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stg_p[k] <= '0;
      end else if (adv) begin
        stg_p[k] <= nxt;
      end
    end

`ifdef PIPE_ADDER_FLAGS_EN
    if (k == STAGES-1) begin : g_flags
      flags_t flg_nxt;

      // Carry into the MSB is recovered from the MSB operand bits and the MSB sum bit.
      always_comb begin
        flg_nxt.ovf  = (src.pa[WIDTH-1] ^ src.pb[WIDTH-1] ^ cs[CHUNK-1]) ^ co;
        flg_nxt.zero = (nxt.psum == '0);
        flg_nxt.neg  = nxt.psum[WIDTH-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          flags_p <= '0;
        end else if (adv) begin
          flags_p <= flg_nxt;
        end
      end
    end
`endif
  end

  assign out_valid = stg_p[STAGES-1].valid;
  assign sum       = stg_p[STAGES-1].psum;
  assign cout      = stg_p[STAGES-1].carry;

`ifdef PIPE_ADDER_FLAGS_EN
  assign ovf  = flags_p.ovf;
  assign zero = flags_p.zero;
  assign neg  = flags_p.neg;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench: 32/8 and 16/16 adders against a plain-arithmetic reference model.
module tb_pipelined_adder;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, out_ready, cin, sub;
  logic [31:0] a, b;
  logic        in_ready, out_valid, cout;
  logic [31:0] sum;
  logic        in_ready2, out_valid2, cout2;
  logic [15:0] sum2;
`ifdef PIPE_ADDER_FLAGS_EN
  logic        ovf, zero, neg, ovf2, zero2, neg2;
`endif

  pipelined_adder #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef PIPE_ADDER_FLAGS_EN
    , .ovf(ovf), .zero(zero), .neg(neg)
`endif
  );

  pipelined_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
    .out_valid(out_valid2), .out_ready(out_ready), .sum(sum2), .cout(cout2)
`ifdef PIPE_ADDER_FLAGS_EN
    , .ovf(ovf2), .zero(zero2), .neg(neg2)
`endif
  );

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic [2:0]  flg;   // {ovf, zero, neg}
  } res_t;

  res_t  q1[$];
  res_t  q2[$];
  int    errors = 0;
  int    checks = 0;
  int    n_out1 = 0;
  logic  prev_stall1 = 1'b0;
  logic [32:0] held1;

  // Reference: a+b+cin or a-b, modulo 2^w; cout is carry (add) or no-borrow (sub).
  function automatic res_t ref_calc(input int w, input logic [31:0] ai, input logic [31:0] bi,
                                    input logic ci, input logic si);
    longint unsigned mask, ua, ub, full;
    logic sa, sb, ss, ov;
    res_t r;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'd0, ai} & mask;
    ub   = {32'd0, bi} & mask;
    if (si) begin
      full   = ua - ub;
      r.cout = (ua >= ub);
    end else begin
      full   = ua + ub + {63'd0, ci};
      r.cout = full[w];
    end
    r.sum = 32'(full & mask);
    sa = ua[w-1];
    sb = ub[w-1];
    ss = r.sum[w-1];
    ov = si ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
    r.flg = {ov, (r.sum == 32'd0), ss};
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) q1.push_back(ref_calc(32, a, b, cin, sub));
      if (prev_stall1) chk("hold32", {31'd0, out_valid, cout, sum}, {31'd0, 1'b1, held1});
      prev_stall1 = out_valid && !out_ready;
      held1       = {cout, sum};
      if (out_valid && out_ready) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious32: got sum %h with no beat outstanding", sum);
        end else begin
          res_t e;
          e = q1.pop_front();
          n_out1++;
          chk("result32", {31'd0, cout, sum}, {31'd0, e.cout, e.sum});
`ifdef PIPE_ADDER_FLAGS_EN
          chk("flags32", {61'd0, ovf, zero, neg}, {61'd0, e.flg});
`endif
        end
      end
    end else begin
      prev_stall1 = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready2) q2.push_back(ref_calc(16, a, b, cin, sub));
      if (out_valid2 && out_ready) begin
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious16: got sum %h with no beat outstanding", sum2);
        end else begin
          res_t e;
          e = q2.pop_front();
          chk("result16", {47'd0, cout2, sum2}, {47'd0, e.cout, e.sum[15:0]});
`ifdef PIPE_ADDER_FLAGS_EN
          chk("flags16", {61'd0, ovf2, zero2, neg2}, {61'd0, e.flg});
`endif
        end
      end
    end
  end

  // One isolated beat: measures latency and checks a hand-computed result.
  task automatic directed(input string name, input logic [31:0] ai, input logic [31:0] bi,
                          input logic ci, input logic si, input logic [31:0] es,
                          input logic ec, input logic [2:0] ef);
    int lat;
    a = ai; b = bi; cin = ci; sub = si; in_valid = 1'b1; out_ready = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 20);
    chk({name, "_latency"}, 64'(lat), 64'(LAT));
    chk({name, "_sum"}, {31'd0, cout, sum}, {31'd0, ec, es});
`ifdef PIPE_ADDER_FLAGS_EN
    chk({name, "_flags"}, {61'd0, ovf, zero, neg}, {61'd0, ef});
`else
    if (ef === 3'bxxx) $display("note: flags undefined for %s", name);
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    int sent, cyc, base, seen;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_sum", {32'd0, sum}, 64'd0);
    chk("reset_cout", {63'd0, cout}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    directed("carry_cross", 32'h0000_00FF, 32'h1, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 3'b000);
    directed("wrap_zero",   32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 3'b010);
    directed("signed_ovf",  32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 3'b101);
    directed("sub_borrow",  32'd5,         32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 3'b001);
    directed("sub_cin_ign", 32'd7,         32'd5, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 3'b000);

    // Ten back-to-back beats with the consumer stalling in cycles 6-8.
    sent = 0;
    base = n_out1;
    for (int c = 0; c < 40 && (sent < 10 || n_out1 < base + 10); c++) begin
      out_ready = !(c >= 6 && c <= 8);
      in_valid  = (sent < 10);
      a   = 32'h0100_0000 * sent + 32'hFF;
      b   = 32'(sent * 3 + 1);
      cin = (sent % 2) != 0;
      sub = 1'b0;
      #1;
      if (c >= 6 && c <= 8) chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("burst_count", 64'(n_out1 - base), 64'd10);
    chk("burst_drained", 64'(q1.size()), 64'd0);

    // Reset with three beats in flight, the first already at the output.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 32'h1234_0000 + 32'(i); b = 32'h11; cin = 1'b0; sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midreset_sum", {32'd0, sum}, 64'd0);
    chk("midreset_cout", {63'd0, cout}, 64'd0);
    q1.delete();
    q2.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid || out_valid2) seen++;
    end
    chk("post_reset_silent", 64'(seen), 64'd0);

    // Randomised traffic with random backpressure.
    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 60000) begin
      in_valid  = $urandom_range(0, 99) < 75;
      out_ready = $urandom_range(0, 99) < 75;
      a   = $urandom;
      b   = $urandom;
      if ($urandom_range(0, 15) == 0) a = 32'hFFFF_FFFF;
      if ($urandom_range(0, 15) == 0) b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0;
      cin = $urandom_range(0, 1) != 0;
      sub = $urandom_range(0, 1) != 0;
      #1;
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    if (sent < 10000) begin
      checks++; errors++;
      $display("FAIL random_timeout: got %0d beats accepted, required 10000", sent);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("final_drain32", 64'(q1.size()), 64'd0);
    chk("final_drain16", 64'(q2.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
